// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard using
// the inhibit / request-to-send / 11-bit frame / ack sequence on open-drain lines.
// The *_oe outputs pull the line low when 1; the top level builds the tri-states.
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic [7:0] txdata,
  input  logic       txstart,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       txbusy,
  output logic       txdone,
  output logic       txerror
);

  // One down-counter serves the inhibit delay and both timeouts.
  localparam int TMAX = (START_TIMEOUT > XFER_TIMEOUT)
                      ? ((START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES)
                      : ((XFER_TIMEOUT  > INHIBIT_CYCLES) ? XFER_TIMEOUT  : INHIBIT_CYCLES);
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_RTS       = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [3:0]    nedge;     // falling edges seen so far in DATA
  logic [7:0]    data_q;
  logic          clk_s1, sync_clk, clk_last;
  logic          dat_s1, sync_dat;
  logic          neg;
  logic          expired;

  assign neg     = clk_last & ~sync_clk;
  assign expired = (timer == '0);

  // Two-flop synchronisers on both pins plus a delayed clock copy for edge detect.
  // Reset to 1 so an idle bus never shows a phantom falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      sync_clk <= 1'b1;
      clk_last <= 1'b1;
      dat_s1   <= 1'b1;
      sync_dat <= 1'b1;
    end else begin
      clk_s1   <= PS2_CLK;
      sync_clk <= clk_s1;
      clk_last <= sync_clk;
      dat_s1   <= PS2_DAT;
      sync_dat <= dat_s1;
    end
  end

  // Transmit sequencer: all outputs are registered so the pins never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      nedge      <= '0;
      data_q     <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      txbusy     <= 1'b0;
      txdone     <= 1'b0;
      txerror    <= 1'b0;
    end else begin
      txdone  <= 1'b0;
      txerror <= 1'b0;
      case (state)
        S_IDLE: begin
          if (txstart) begin
            data_q     <= txdata;
            txbusy     <= 1'b1;
            ps2_clk_oe <= 1'b1;
            timer      <= TW'(INHIBIT_CYCLES - 1);
            state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (expired) begin
            ps2_dat_oe <= 1'b1;              // start bit
            state      <= S_RTS;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_RTS: begin
          ps2_clk_oe <= 1'b0;                // hand the clock to the device
          timer      <= TW'(START_TIMEOUT);
          nedge      <= '0;
          state      <= S_DATA;
        end
        S_DATA: begin
          if (expired) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            txbusy     <= 1'b0;
            txerror    <= 1'b1;
            state      <= S_IDLE;
          end else begin
            timer <= timer - TW'(1);
            if (neg) begin
              nedge <= nedge + 4'd1;
              if (nedge == 4'd0) timer <= TW'(XFER_TIMEOUT);
              if (nedge < 4'd8) begin
                ps2_dat_oe <= ~data_q[nedge[2:0]];
              end else if (nedge == 4'd8) begin
                ps2_dat_oe <= ^data_q;       // odd parity bit is ~^data, pulled when 0
              end else begin
                ps2_dat_oe <= 1'b0;          // stop bit
                state      <= S_ACK;
              end
            end
          end
        end
        S_ACK: begin
          if (expired || (neg && sync_dat)) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            txbusy     <= 1'b0;
            txerror    <= 1'b1;
            state      <= S_IDLE;
          end else begin
            timer <= timer - TW'(1);
            if (neg) state <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (expired) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            txbusy     <= 1'b0;
            txerror    <= 1'b1;
            state      <= S_IDLE;
          end else if (sync_clk && sync_dat) begin
            txbusy <= 1'b0;
            txdone <= 1'b1;
            state  <= S_IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: a PS/2 device model clocks frames out of the host,
// a cycle-level model tracks busy / inhibit / RTS timing, and frames captured
// by the device are compared with frames built from the byte sent.
module tb_ps2_transmitter;
  localparam int INH = 50;
  localparam int STO = 2000;
  localparam int XTO = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] txdata = 8'h00;
  logic       txstart = 1'b0;
  logic       PS2_CLK, PS2_DAT;
  logic       ps2_clk_oe, ps2_dat_oe, txbusy, txdone, txerror;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic [10:0] dev_smp = '1;
  int         dev_dly = 10;

  int errors = 0;
  int checks = 0;

  // Bench expectations for the transaction in flight.
  bit exp_kind = 1'b0;   // 1 = txerror expected, 0 = txdone expected
  bit exp_tmo  = 1'b0;   // error must come from the start timeout

  // Open-drain wiring: a line is high only if nobody pulls it low.
  assign PS2_CLK = dev_clk & ~ps2_clk_oe;
  assign PS2_DAT = dev_dat & ~ps2_dat_oe;

  ps2_transmitter #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(STO), .XFER_TIMEOUT(XTO)) dut (
    .clk(clk), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .txdata(txdata), .txstart(txstart),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .txbusy(txbusy), .txdone(txdone), .txerror(txerror)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame as the device sees it: [0]=start 0, [8:1]=data LSB first, [9]=odd parity, [10]=stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    frame_of = {1'b1, ((ones % 2) == 0), d, 1'b0};
  endfunction

  // ---------------- cycle model + per-cycle compare ----------------
  logic rst_q = 1'b1;
  logic st_q  = 1'b0;
  bit   in_tx = 1'b0;
  int   k     = 0;    // cycles since accept; 1 = first busy cycle

  // Inputs as the DUT sampled them at this edge.
  always @(posedge clk) begin
    rst_q <= reset;
    st_q  <= txstart;
  end

  // Compare DUT outputs with the model mid-cycle.
  always @(negedge clk) begin
    bit pulse;
    if (rst_q)       in_tx = 1'b0;
    else if (in_tx)  k++;
    else if (st_q) begin in_tx = 1'b1; k = 1; end

    pulse = txdone | txerror;
    chk("done_err_excl", {31'd0, txdone & txerror}, 32'd0);
    if (pulse) begin
      chk("pulse_in_tx", {31'd0, in_tx}, 32'd1);
      if (in_tx) begin
        chk("pulse_kind", {31'd0, txerror}, {31'd0, exp_kind});
        chk("pulse_after_rts", {31'd0, k > INH + 2}, 32'd1);
        if (exp_tmo) begin
          checks++;
          if (k < INH + 1 + STO - 2 || k > INH + 1 + STO + 2) begin
            errors++;
            $display("FAIL tmo_cycle: got %0d expected %0d +/-2", k, INH + 1 + STO);
          end
        end
      end
    end
    chk("txbusy", {31'd0, txbusy}, {31'd0, in_tx && !pulse});
    chk("clk_oe", {31'd0, ps2_clk_oe}, {31'd0, in_tx && !pulse && k <= INH + 1});
    if (!in_tx || pulse || k <= INH)
      chk("dat_oe_off", {31'd0, ps2_dat_oe}, 32'd0);
    else if (k <= INH + 2)
      chk("dat_oe_rts", {31'd0, ps2_dat_oe}, 32'd1);
    if (pulse) in_tx = 1'b0;
  end

  // ---------------- device model ----------------
  task automatic device_frame(input int ncyc, input bit ack);
    int t;
    t = 0;
    while (!(PS2_CLK === 1'b1 && PS2_DAT === 1'b0) && t < 5000) begin
      @(negedge clk); t++;
    end
    if (t >= 5000) begin
      checks++; errors++;
      $display("FAIL dev_rts: got no request-to-send within %0d cycles", t);
      return;
    end
    repeat (dev_dly) @(negedge clk);
    dev_smp    = '1;
    dev_smp[0] = PS2_DAT;
    for (int i = 1; i <= ncyc; i++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) dev_smp[i] = PS2_DAT;
      if (i == 10 && ack) dev_dat = 1'b0;
      if (i == 11) dev_dat = 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_end(input bit chain, input logic [7:0] cd);
    int t;
    t = 0;
    while (!(txdone === 1'b1 || txerror === 1'b1) && t < 25000) begin
      @(negedge clk); t++;
    end
    if (t >= 25000) begin
      checks++; errors++;
      $display("FAIL end_timeout: got no txdone/txerror within %0d cycles", t);
    end else begin
      chk("txdone", {31'd0, txdone}, {31'd0, !exp_kind});
      chk("txerror", {31'd0, txerror}, {31'd0, exp_kind});
      if (chain) begin
        txdata = cd; txstart = 1'b1;
        @(negedge clk);
        txstart = 1'b0; txdata = 8'($urandom);
      end
    end
  endtask

  task automatic xact(input logic [7:0] d, input int ncyc, input bit ack, input bit err,
                      input bit tmo, input bit pre, input int spur, input bit chain,
                      input logic [7:0] cd);
    exp_kind = err;
    exp_tmo  = tmo;
    dev_dly  = $urandom_range(5, 60);
    if (!pre) begin
      @(negedge clk);
      txdata = d; txstart = 1'b1;
      @(negedge clk);
      txstart = 1'b0; txdata = 8'($urandom);
    end
    dev_smp = '1;
    fork
      if (ncyc > 0) device_frame(ncyc, ack);
      if (spur > 0) begin
        repeat (spur) @(negedge clk);
        txdata = 8'h55; txstart = 1'b1;
        @(negedge clk);
        txstart = 1'b0;
      end
      wait_end(chain, cd);
    join
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    chk("rst_busy",   {31'd0, txbusy},     32'd0);
    chk("rst_done",   {31'd0, txdone},     32'd0);
    chk("rst_err",    {31'd0, txerror},    32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 0xED: frame 0,1,0,1,1,0,1,1,1,1,1
    xact(8'hED, 11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00);
    chk("ed_frame", {21'd0, dev_smp}, {21'd0, 11'h7DA});
    chk("ed_model", {21'd0, dev_smp}, {21'd0, frame_of(8'hED)});

    // Parity corners.
    xact(8'h01, 11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00);
    chk("par_01", {31'd0, dev_smp[9]}, 32'd0);
    chk("frm_01", {21'd0, dev_smp}, {21'd0, frame_of(8'h01)});
    xact(8'h00, 11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00);
    chk("par_00", {31'd0, dev_smp[9]}, 32'd1);
    xact(8'hFF, 11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00);
    chk("par_ff", {31'd0, dev_smp[9]}, 32'd1);
    chk("frm_ff", {21'd0, dev_smp}, {21'd0, frame_of(8'hFF)});

    // Device never clocks: start timeout.
    xact(8'h3C, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'h00);
    @(negedge clk);
    chk("tmo_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("tmo_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    chk("tmo_busy",   {31'd0, txbusy},     32'd0);

    // Missing ack.
    xact(8'hA5, 11, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00);
    chk("noack_frame", {21'd0, dev_smp}, {21'd0, frame_of(8'hA5)});

    // Mid-frame txstart ignored; 0x55 started on the txdone cycle.
    xact(8'hED, 11, 1'b1, 1'b0, 1'b0, 1'b0, 150, 1'b1, 8'h55);
    chk("spur_frame", {21'd0, dev_smp}, {21'd0, 11'h7DA});
    xact(8'h55, 11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00);
    chk("b2b_frame", {21'd0, dev_smp}, {21'd0, 11'h6AA});

    // Reset in the middle of the data bits.
    exp_kind = 1'b0; exp_tmo = 1'b0; dev_dly = 12;
    @(negedge clk);
    txdata = 8'hA7; txstart = 1'b1;
    @(negedge clk);
    txstart = 1'b0;
    device_frame(5, 1'b0);
    chk("mid_busy_before", {31'd0, txbusy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("mid_rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    chk("mid_rst_busy",   {31'd0, txbusy},     32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    xact(8'hF4, 11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00);
    chk("f4_frame", {21'd0, dev_smp}, {21'd0, 11'h5E8});

    // Random bytes.
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom);
      xact(d, 11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00);
      chk("rand_frame", {21'd0, dev_smp}, {21'd0, frame_of(d)});
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
